// File: rtl/sdram_port_arb.sv
// Three-client arbiter for the toggle-handshake SDRAM port1 of the MiST controller.
// Round-robin with optional client-0 priority and an optional one-word read cache per client.
module sdram_port_arb #(
  parameter bit PRIO0 = 1'b1,
  parameter bit CACHE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [68:0] a,
  input  logic [5:0]  ds,
  input  logic [47:0] d,
  output logic [2:0]  ack,
  output logic [15:0] q,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port1_we,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  input  logic [15:0] port1_q,
  output logic [1:0]  state_dbg
);

  // Client handshake: a client holds req[n] and its we/a/ds/d fields stable
  // until ack[n] pulses for one cycle; holding req past the ack is a new request.
  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  ptr;
  logic [22:0] tag_a [3];
  logic [15:0] tag_d [3];
  logic [2:0]  tag_v;

  logic [22:0] cl_a  [3];
  logic [1:0]  cl_ds [3];
  logic [15:0] cl_d  [3];

  logic [1:0]  sel;
  logic        sel_vld;
  logic [1:0]  cand;
  logic [22:0] sel_a;
  logic        sel_we;
  logic [1:0]  sel_ds;
  logic [15:0] sel_d;
  logic        hit;
  logic        p1_match;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] t;
    t = (v >= 3'd3) ? v - 3'd3 : v;
    return t[1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cl_a[k]  = a[k*23 +: 23];
      cl_ds[k] = ds[k*2 +: 2];
      cl_d[k]  = d[k*16 +: 16];
    end
  end

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    sel     = 2'd0;
    sel_vld = 1'b0;
    cand    = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = wrap3({1'b0, ptr} + 3'(k));
      if (req[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
    if (PRIO0 && req[0]) sel = 2'd0;
  end

  assign sel_a    = cl_a[sel];
  assign sel_we   = we[sel];
  assign sel_ds   = cl_ds[sel];
  assign sel_d    = cl_d[sel];
  assign hit      = CACHE && !sel_we && tag_v[sel] && (tag_a[sel] == sel_a);
  assign p1_match = (port1_ack == port1_req);

  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC:  if (p1_match) state_nxt = S_IDLE;
      S_IDLE:  if (sel_vld) state_nxt = hit ? S_DONE : S_WAIT;
      S_WAIT:  if (p1_match) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_SYNC;
      ptr       <= 2'd0;
      grant     <= 2'd3;
      ack       <= 3'b000;
      q         <= 16'h0000;
      port1_req <= 1'b0;
      port1_we  <= 1'b0;
      port1_a   <= 23'h0;
      port1_ds  <= 2'b00;
      port1_d   <= 16'h0000;
      tag_v     <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        tag_a[k] <= 23'h0;
        tag_d[k] <= 16'h0000;
      end
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            grant <= sel;
            if (hit) begin
              q   <= tag_d[sel];
              ack <= 3'b001 << sel;
            end else begin
              port1_req <= ~port1_req;
              port1_we  <= sel_we;
              port1_a   <= sel_a;
              port1_ds  <= sel_ds;
              port1_d   <= sel_d;
              // A write makes any cached copy of that word stale, whoever owns it.
              if (sel_we) begin
                for (int k = 0; k < 3; k++) begin
                  if (tag_a[k] == sel_a) tag_v[k] <= 1'b0;
                end
              end
            end
          end
        end
        S_WAIT: begin
          if (p1_match) begin
            ack <= 3'b001 << grant;
            if (!port1_we) begin
              q <= port1_q;
              if (CACHE) begin
                tag_a[grant] <= port1_a;
                tag_d[grant] <= port1_q;
                tag_v[grant] <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          ack   <= 3'b000;
          ptr   <= wrap3({1'b0, grant} + 3'd1);
          grant <= 2'd3;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: behavioural SDRAM responders, a transaction-level
// memory/cache model, directed scenarios and a randomized transaction run.
module tb_sdram_port_arb;

  localparam logic [1:0] ST_SYNC = 2'd0;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req   = '0;
  logic [2:0]  we    = '0;
  logic [68:0] a     = '0;
  logic [5:0]  ds    = '0;
  logic [47:0] d     = '0;

  logic [2:0]  u_ack;
  logic [15:0] u_q;
  logic        u_busy;
  logic [1:0]  u_grant, u_state;
  logic        p1_req, p1_we;
  logic [22:0] p1_a;
  logic [1:0]  p1_ds;
  logic [15:0] p1_d;
  logic        p1_ack = 1'b1;
  logic [15:0] p1_q   = '0;

  logic [2:0]  rr_ack;
  logic [15:0] rr_q;
  logic        rr_busy;
  logic [1:0]  rr_grant, rr_state;
  logic        rr_p1_req, rr_p1_we;
  logic [22:0] rr_p1_a;
  logic [1:0]  rr_p1_ds;
  logic [15:0] rr_p1_d;
  logic        rr_p1_ack = 1'b0;
  logic [15:0] rr_p1_q   = '0;

  sdram_port_arb #(.PRIO0(1'b1), .CACHE(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .a(a), .ds(ds), .d(d),
    .ack(u_ack), .q(u_q), .busy(u_busy), .grant(u_grant),
    .port1_req(p1_req), .port1_ack(p1_ack), .port1_we(p1_we), .port1_a(p1_a),
    .port1_ds(p1_ds), .port1_d(p1_d), .port1_q(p1_q), .state_dbg(u_state)
  );

  sdram_port_arb #(.PRIO0(1'b0), .CACHE(1'b0)) u_rr (
    .clk(clk), .reset(reset), .req(req), .we(we), .a(a), .ds(ds), .d(d),
    .ack(rr_ack), .q(rr_q), .busy(rr_busy), .grant(rr_grant),
    .port1_req(rr_p1_req), .port1_ack(rr_p1_ack), .port1_we(rr_p1_we), .port1_a(rr_p1_a),
    .port1_ds(rr_p1_ds), .port1_d(rr_p1_d), .port1_q(rr_p1_q), .state_dbg(rr_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SDRAM responder models ----------------
  int          p1_lat = 6;
  int          p1_cnt = 0;
  int          acc_cnt = 0;
  logic        acc_we_last = 1'b1;
  logic        mem_loaded = 1'b0;
  logic [15:0] mem [256];
  int          rr_cnt = 0;

  function automatic logic [15:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (b == 8'h34) return 16'hBEEF;
    return {b ^ 8'hC0, b};
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (p1_req != p1_ack) begin
      if (p1_cnt >= p1_lat - 1) begin
        p1_cnt      <= 0;
        p1_ack      <= p1_req;
        acc_cnt     <= acc_cnt + 1;
        acc_we_last <= p1_we;
        if (p1_we)
          mem[p1_a[7:0]] <= {p1_ds[1] ? p1_d[15:8] : mem[p1_a[7:0]][15:8],
                             p1_ds[0] ? p1_d[7:0]  : mem[p1_a[7:0]][7:0]};
        else
          p1_q <= mem[p1_a[7:0]];
      end else begin
        p1_cnt <= p1_cnt + 1;
      end
    end else begin
      p1_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (rr_p1_req != rr_p1_ack) begin
      if (rr_cnt >= 1) begin
        rr_cnt    <= 0;
        rr_p1_ack <= rr_p1_req;
        rr_p1_q   <= rr_p1_a[15:0] ^ 16'hA5A5;
      end else begin
        rr_cnt <= rr_cnt + 1;
      end
    end else begin
      rr_cnt <= 0;
    end
  end

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_mem [256];
  logic        cv [3];
  logic [22:0] ca [3];
  logic [15:0] last_q = 16'h0000;
  int          u_ack_cnt [3] = '{0, 0, 0};
  int          exp_ack_cnt [3] = '{0, 0, 0};
  logic        mon_en = 1'b0;
  logic [1:0]  exp_q [$];
  logic [1:0]  du_seen [$];
  logic [1:0]  rr_seen [$];
  logic [15:0] du_qs [$];
  logic [15:0] rr_qs [$];
  logic [22:0] tbl [6] = '{23'h001234, 23'h000056, 23'h7FFF78, 23'h0ABC9A, 23'h0012BC, 23'h3000DE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [2:0] v);
    return v[2] ? 2'd2 : (v[1] ? 2'd1 : 2'd0);
  endfunction

  // Ack monitor: every ack must be one-hot and belong to a requesting client.
  always @(negedge clk) begin
    if (u_ack != 3'b000) begin
      check("ack_onehot", 32'($onehot(u_ack)), 32'd1);
      check("ack_has_req", 32'(u_ack & ~req), 32'd0);
      if (mon_en) begin
        du_seen.push_back(oh_idx(u_ack));
        du_qs.push_back(u_q);
      end else begin
        for (int k = 0; k < 3; k++)
          if (u_ack[k]) u_ack_cnt[k] <= u_ack_cnt[k] + 1;
      end
    end
    if (mon_en && rr_ack != 3'b000) begin
      check("rr_ack_onehot", 32'($onehot(rr_ack)), 32'd1);
      rr_seen.push_back(oh_idx(rr_ack));
      rr_qs.push_back(rr_q);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_xact(input int c, input logic wr, input logic [22:0] addr,
                         input logic [15:0] data, input logic [1:0] bs);
    int          n, tg;
    logic        prev, exp_hit;
    logic [15:0] exp_val, old;
    logic [7:0]  ix;
    ix      = addr[7:0];
    exp_hit = !wr && cv[c] && (ca[c] == addr);
    exp_val = exp_mem[ix];
    @(negedge clk);
    we[c] = wr;
    a[c*23 +: 23] = addr;
    ds[c*2 +: 2] = bs;
    d[c*16 +: 16] = data;
    req[c] = 1'b1;
    prev = p1_req;
    tg = 0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (p1_req != prev) tg++;
      prev = p1_req;
      if (n == 1 && !exp_hit) begin
        check("issue_toggle", tg, 1);
        check("issue_addr", 32'(p1_a), 32'(addr));
        check("issue_we", 32'(p1_we), 32'(wr));
        if (wr) begin
          check("issue_ds", 32'(p1_ds), 32'(bs));
          check("issue_d", 32'(p1_d), 32'(data));
        end
      end
      if (u_ack[c]) break;
    end
    check("ack_seen", 32'(u_ack[c]), 32'd1);
    check("latency", n, exp_hit ? 1 : p1_lat + 2);
    check("sdram_toggles", tg, exp_hit ? 0 : 1);
    if (!wr) check("rd_data", 32'(u_q), 32'(exp_val));
    else     check("wr_q_hold", 32'(u_q), 32'(last_q));
    #1;
    req[c] = 1'b0;
    exp_ack_cnt[c]++;
    if (wr) begin
      old = exp_mem[ix];
      exp_mem[ix] = {bs[1] ? data[15:8] : old[15:8], bs[0] ? data[7:0] : old[7:0]};
      for (int k = 0; k < 3; k++)
        if (ca[k] == addr) cv[k] = 1'b0;
    end else begin
      last_q = exp_val;
      if (!exp_hit) begin
        cv[c] = 1'b1;
        ca[c] = addr;
      end
    end
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cv[k] = 1'b0;
    last_q = 16'h0000;
    n = 0;
    while ((u_busy || rr_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resync_done", 32'(u_busy | rr_busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, acks;
    logic [1:0] bs;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    for (int k = 0; k < 3; k++) begin
      cv[k] = 1'b0;
      ca[k] = '0;
    end

    // Reset with the controller holding a toggle mismatch.
    @(negedge clk);
    check("rst_ack", 32'(u_ack), 32'd0);
    check("rst_q", 32'(u_q), 32'd0);
    check("rst_grant", 32'(u_grant), 32'd3);
    check("rst_p1_req", 32'(p1_req), 32'd0);
    check("rst_p1_a", 32'(p1_a), 32'd0);
    check("rst_p1_we", 32'(p1_we), 32'd0);
    check("rst_state", 32'(u_state), 32'(ST_SYNC));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("sync_busy", 32'(u_busy), 32'd1);
    n = 0;
    while (u_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sync_exit", 32'(u_busy), 32'd0);
    check("spurious_cnt", acc_cnt, 1);
    check("spurious_is_read", 32'(acc_we_last), 32'd0);
    check("idle_grant", 32'(u_grant), 32'd3);

    // Read miss, cached re-read, write invalidation, re-read from SDRAM.
    do_xact(1, 1'b0, 23'h001234, 16'h0000, 2'b11);
    do_xact(1, 1'b0, 23'h001234, 16'h0000, 2'b11);
    do_xact(0, 1'b1, 23'h001234, 16'h5555, 2'b11);
    do_xact(1, 1'b0, 23'h001234, 16'h0000, 2'b11);
    check("reread_value", 32'(u_q), 32'h5555);

    // Reset in the middle of an SDRAM access.
    @(negedge clk);
    we[2] = 1'b0;
    a[46 +: 23] = tbl[3];
    req[2] = 1'b1;
    repeat (3) @(negedge clk);
    check("midwait_busy", 32'(u_busy), 32'd1);
    check("midwait_grant", 32'(u_grant), 32'd2);
    reset = 1'b1;
    req[2] = 1'b0;
    #1;
    check("midwait_rst_state", 32'(u_state), 32'(ST_SYNC));
    check("midwait_rst_ack", 32'(u_ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cv[k] = 1'b0;
    last_q = 16'h0000;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_ack != 3'b000) acks++;
    end
    check("midwait_no_ack", acks, 0);
    check("midwait_idle", 32'(u_busy), 32'd0);
    check("midwait_q_reset", 32'(u_q), 32'd0);
    do_xact(2, 1'b0, tbl[3], 16'h0000, 2'b11);

    // All three clients requesting continuously.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      we[k] = 1'b0;
      a[k*23 +: 23] = tbl[k+1];
    end
    req = 3'b111;
    mon_en = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    req = 3'b000;
    mon_en = 1'b0;
    repeat (20) @(negedge clk);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    check("rr_ack_count", 32'(rr_seen.size() >= 6), 32'd1);
    check("prio_ack_count", 32'(du_seen.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < rr_seen.size(); i++) begin
      check("rr_order", 32'(rr_seen[i]), 32'(exp_q[i]));
      check("rr_data", 32'(rr_qs[i]), 32'(tbl[exp_q[i] + 1][15:0] ^ 16'hA5A5));
    end
    for (int i = 0; i < 6 && i < du_seen.size(); i++) begin
      check("prio_order", 32'(du_seen[i]), 32'd0);
      check("prio_data", 32'(du_qs[i]), 32'(exp_mem[tbl[1][7:0]]));
    end
    cv[0] = 1'b1;
    ca[0] = tbl[1];
    last_q = exp_mem[tbl[1][7:0]];

    // Randomized single-client transactions.
    for (int i = 0; i < 60; i++) begin
      p1_lat = $urandom_range(1, 7);
      bs = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0)
        do_xact($urandom_range(0, 2), 1'b1, tbl[$urandom_range(0, 5)], 16'($urandom), bs);
      else
        do_xact($urandom_range(0, 2), 1'b0, tbl[$urandom_range(0, 5)], 16'h0000, 2'b11);
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) check("ack_total", u_ack_cnt[k], exp_ack_cnt[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Shares the single toggle-handshake SDRAM port (port1_req/port1_ack) of the MiST SDRAM controller among three clients.
- Typical clients: 0 = ROM download writer, 1 = sprite/gfx fetch, 2 = sound ROM.
- Each client sees a simple level-request / one-cycle-ack interface.
- The block arbitrates (round-robin, with optional client-0 priority), holds downstream signals stable for the whole access, and provides an optional one-entry read cache per client.

Parameters:
- PRIO0, 1, 1 = client 0 always wins when requesting; 0 = pure round-robin.
- CACHE, 1, 1 = enable one-entry read cache per client; 0 = every request goes to SDRAM.

Ports:
- clk  in  1  SDRAM clock, same clock as the SDRAM controller.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  per-client level request; client n holds req[n] and its fields stable until ack[n].
- we  in  3  per-client write enable (1 = write).
- a  in  69  per-client word address [23:1], packed; client n uses a[23n+22:23n].
- ds  in  6  per-client byte strobes, 2 bits per client.
- d  in  48  per-client write data, 16 bits per client.
- ack  out  3  one-cycle completion pulse per client.
- q  out  16  read data; valid in the ack cycle; holds until the next ack.
- busy  out  1  high in SYNC, WAIT and DONE.
- grant  out  2  index of the client being served; 3 when idle.
- port1_req  out  1  toggle request to the SDRAM controller.
- port1_ack  in  1  equals port1_req when the access is complete.
- port1_we  out  1  write enable to the SDRAM controller.
- port1_a  out  23  word address to the SDRAM controller.
- port1_ds  out  2  byte strobes to the SDRAM controller.
- port1_d  out  16  write data to the SDRAM controller.
- port1_q  in  16  read data from the SDRAM controller.

Behaviour:
- Reset values: port1_req=0, port1_we=0, port1_a=0, port1_ds=0, port1_d=0, ack=0, q=0, grant=3, rr pointer=0, all cache tags invalid, state=SYNC.
- SYNC:
  - Stay in SYNC until port1_ack==port1_req, then go to IDLE.
  - Reset can leave the controller with a toggle mismatch. That produces at most one spurious access, and it is a read because port1_we resets to 0.
- IDLE, selection:
  - Scan order is ptr, ptr+1, ptr+2 (mod 3).
  - If PRIO0=1 and req[0]=1, client 0 is selected regardless of ptr.
  - If no request is pending: stay in IDLE, grant=3.
- IDLE, cache hit (CACHE=1, selected request is a read, client tag valid, tag address == a):
  - Next edge: q<=cached word, ack[g]<=1, state<=DONE.
  - No SDRAM access is made.
- IDLE, otherwise (miss or write):
  - Next edge: latch we/a/ds/d of client g into port1_*; port1_req<=~port1_req; grant<=g; state<=WAIT.
- WAIT:
  - port1_* stay constant throughout.
  - When port1_ack==port1_req: for a read, q<=port1_q; ack[g]<=1; state<=DONE.
- DONE:
  - ack<=0; ptr<=(g+1) mod 3; grant<=3; state<=IDLE.
  - A client that keeps req high after its ack cycle is treated as issuing a new request.
- Latency:
  - Cache hit: ack one cycle after req is first seen in IDLE.
  - Miss: ack one cycle after the clock in which port1_ack matches.
  - Back-to-back: a new grant is possible two cycles after the previous ack.
- Cache (CACHE=1):
  - Completed SDRAM read for client n: set tag[n]=a, valid[n]=1, data[n]=port1_q.
  - ds is not part of the tag; the full word is cached.
  - Any write issued by any client invalidates every tag whose address equals the write address. Invalidation happens in the cycle the write is issued.
  - A write never fills a tag.
- ack is never asserted for a client that was not granted, and at most one ack bit is high at a time.
- Reset during WAIT or DONE:
  - The outstanding ack is lost; the client must re-request.
  - The state returns to SYNC.

Test Plan:
- Reset with the SDRAM model holding port1_ack=1 -> busy=1 until the model completes one read access (port1_we=0); then IDLE, grant=3.
- Single read, client 1, a=0x001234, model returns 0xBEEF 6 cycles after the toggle -> port1_a=0x001234 and port1_req toggles the cycle after req; ack[1] pulses for one cycle with q=0xBEEF.
- Same read repeated, CACHE=1 -> ack[1] one cycle after req, q=0xBEEF, port1_req unchanged.
- Client 0 writes 0x5555 to 0x001234, then client 1 re-reads -> the re-read goes to SDRAM (port1_req toggles) and returns the model value 0x5555.
- req=3'b111 held continuously, PRIO0=0 -> grant sequence 0,1,2,0,...; with PRIO0=1 -> always 0.
- Reset asserted mid-WAIT -> ack stays 0, state returns to SYNC, no duplicate ack after recovery.
